jk_bank_ctrl: RTL and testbench
===============================

# jk_bank_ctrl

Command-driven sequencer for a bank of WIDTH external JK flip-flops sharing the same `clk`. It accepts one command at a time over a valid/ready handshake and drives the bank's J/K lines: parallel load, clear, masked toggle, or N-cycle up/down count. It then reads the bank back through `q` and reports the result with a one-cycle `done` pulse. It sits between a host sequencer and the JK flop bank and is the only driver of the bank's J/K inputs.

## Interface
- `WIDTH`, default 4: number of JK flip-flops in the bank.
- `CNT_W`, default 8: width of the count-length field.
- `clk` input, 1: rising-edge clock, shared with the JK bank.
- `rst_n` input, 1: synchronous, active-low reset.
- `cmd_valid` input, 1: command present.
- `cmd_ready` output, 1: block can accept a command.
- `cmd_op` input, 3: opcode.
- `cmd_data` input, WIDTH: load value or toggle mask.
- `cmd_len` input, CNT_W: count cycles, used only by COUNT ops.
- `j` output, WIDTH: J drive to the bank.
- `k` output, WIDTH: K drive to the bank.
- `q` input, WIDTH: bank outputs.
- `busy` output, 1: high whenever state is not IDLE.
- `done` output, 1: one-cycle completion pulse.
- `result` output, WIDTH: bank value captured at completion; held until the next completion.
- `err` output, 1: one-cycle pulse, coincident with `done`, for an illegal opcode.

## Operation
- Opcodes:
  - 000 NOP.
  - 001 LOAD: j=`cmd_data`, k=~`cmd_data`.
  - 010 CLEAR: j=0, k=all ones.
  - 011 TOGGLE: j=k=`cmd_data`.
  - 100 COUNT_UP.
  - 101 COUNT_DOWN.
  - 110 and 111 are illegal.
- `cmd_op`, `cmd_data` and `cmd_len` are latched on acceptance. Later changes on those inputs are ignored.
- `cmd_ready` = (state==IDLE) && `rst_n`. A command is accepted on a rising edge where `cmd_valid` && `cmd_ready`.
- FSM states: IDLE, DRIVE, RUN, CAPTURE.
  - IDLE → DRIVE on accepting LOAD, CLEAR or TOGGLE.
  - IDLE → RUN on accepting COUNT_* with `cmd_len` ≠ 0; the remaining-cycle counter loads `cmd_len`.
  - IDLE → CAPTURE on accepting NOP, an illegal opcode, or COUNT_* with `cmd_len` = 0.
  - DRIVE → CAPTURE after exactly one cycle.
  - RUN stays for exactly `cmd_len` cycles, decrementing the counter each cycle, then → CAPTURE.
  - CAPTURE → IDLE after one cycle. On that edge: `result` <= `q`, `done` <= 1, and `err` <= 1 if the opcode was illegal.
- `j`/`k` are combinational from state, latched command and `q`. They are all zeros in IDLE and CAPTURE.
- In DRIVE, `j`/`k` follow the opcode table above.
- In RUN, j = k = toggle vector t, recomputed every cycle from `q`:
  - COUNT_UP: t[0]=1; t[i]=&q[i-1:0].
  - COUNT_DOWN: t[0]=1; t[i]=&~q[i-1:0].
- Counting is modulo 2^WIDTH. All-ones up wraps to 0; 0 down wraps to all-ones. No overflow flag.
- A `cmd_valid` held high while busy is not accepted and not dropped. It is accepted on the first edge where `cmd_ready` is 1, which can be the edge that ends a command.
- Illegal opcodes and NOP never drive `j`/`k`.

## Timing
- Reset: at the first edge with `rst_n`=0:
  - state goes to IDLE;
  - `done`, `err` and `busy` go to 0;
  - `result` goes to 0;
  - the counter clears;
  - `j`=`k`=0 from that edge on.
- `cmd_ready` is 0 while `rst_n` is low.
- The JK bank is not reset by this block. Its contents persist across a controller reset.
- Reset mid-operation: the command is aborted with no `done`. The bank keeps however many updates were already applied.
- Latency, with accept at edge E0:
  - LOAD, CLEAR, TOGGLE: DRIVE is [E0,E1), the bank updates at E1, CAPTURE is [E1,E2), `done` is high in [E2,E3).
  - COUNT with len N ≥ 1: the bank updates at E1..EN, `done` is high in [EN+1, EN+2).
  - NOP, illegal opcode, or len 0: `done` is high in [E1,E2).
- Back-to-back throughput: one command per (latency + 0) cycles. The block is IDLE in the `done` cycle and can accept a new command then.

## Test plan
Bench uses WIDTH=4, with a behavioural JK bank model driven by `j`/`k` and feeding `q`.
- Reset: hold `rst_n`=0 for 2 cycles, bank preset to 0x3 → `j`=`k`=0, `cmd_ready`=0, `busy`=`done`=`err`=0, `result`=0; after release `cmd_ready`=1 and the bank is still 0x3.
- LOAD 0xA accepted at E0 → in [E0,E1) j=1010 and k=0101; `done`=1 only in [E2,E3); `result`=0xA.
- TOGGLE 0x5 from 0xA → `result`=0xF. Then COUNT_UP len=3 → bank goes 0x0, 0x1, 0x2 (wraps); `done` in cycle E4; `result`=0x2.
- COUNT_DOWN len=0 with bank at 0x2 → `j`/`k` stay 0; `done` in [E1,E2); `result`=0x2. Then COUNT_DOWN len=3 → `result`=0xF.
- Opcode 110 → `err`=`done`=1 in the same cycle, bank unchanged. Keep `cmd_valid` high with LOAD 0x6 during a busy COUNT → accepted only on the edge where `cmd_ready`=1, then `result`=0x6.
- COUNT_UP len=10 from 0x0, `rst_n` low after 4 RUN cycles → no `done`, `j`=`k`=0 after that edge, bank=0x4, `cmd_ready`=1 after release.

Source files
------------

// File: rtl/jk_bank_ctrl.sv
// Command sequencer that drives the J/K inputs of an external bank of JK flops:
// load, clear, masked toggle and N-cycle up/down count, then reads the bank back.
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_valid may stay high while the block is busy; it is then taken on the
  // first edge with cmd_ready high. cmd_op/cmd_data/cmd_len are latched at that edge.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_CLEAR  = 3'b010;
  localparam logic [2:0] OP_TOGGLE = 3'b011;
  localparam logic [2:0] OP_UP     = 3'b100;
  localparam logic [2:0] OP_DOWN   = 3'b101;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic             accept;
  logic             op_illegal;

  assign cmd_ready  = (state == ST_IDLE) && rst_n;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;
  assign op_illegal = (op_q == 3'b110) || (op_q == 3'b111);

  // Ripple-carry style toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q[i-1];
      t_dn[i] = t_dn[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    case (state)
      ST_DRIVE: begin
        case (op_q)
          OP_LOAD: begin
            j = data_q;
            k = ~data_q;
          end
          OP_CLEAR: begin
            k = '1;
          end
          OP_TOGGLE: begin
            j = data_q;
            k = data_q;
          end
          default: ;
        endcase
      end
      ST_RUN: begin
        if (op_q == OP_DOWN) begin
          j = t_dn;
          k = t_dn;
        end else begin
          j = t_up;
          k = t_up;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_NOP;
      data_q <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            case (cmd_op)
              OP_LOAD, OP_CLEAR, OP_TOGGLE: state <= ST_DRIVE;
              OP_UP, OP_DOWN: begin
                if (cmd_len != '0) begin
                  cnt   <= cmd_len;
                  state <= ST_RUN;
                end else begin
                  state <= ST_CAPTURE;
                end
              end
              default: state <= ST_CAPTURE;
            endcase
          end
        end
        ST_DRIVE: state <= ST_CAPTURE;
        ST_RUN: begin
          // cnt holds the cycles still to run including this one
          cnt <= cnt - 1'b1;
          if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          result <= q;
          done   <= 1'b1;
          err    <= op_illegal;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl with a behavioural 4-bit JK bank wired to j/k/q.
module tb_jk_bank_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_len;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] bank;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;
  logic [1:0]       dbg_state;

  logic             preset_en;
  logic [WIDTH-1:0] preset_val;

  // Expected {err, result} per command, pushed when the command is driven.
  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH:0]   exp;

  int n_checks;
  int n_fail;
  int cyc;
  bit seen;

  jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .q         (bank),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural JK bank: 00 hold, 01 reset, 10 set, 11 toggle.
  always @(posedge clk) begin
    if (preset_en) begin
      bank <= preset_val;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (j[i] && k[i])  bank[i] <= ~bank[i];
        else if (j[i])     bank[i] <= 1'b1;
        else if (k[i])     bank[i] <= 1'b0;
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] data,
                       input logic [CNT_W-1:0] len, input logic [WIDTH:0] expect_v);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    exp_q.push_back(expect_v);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = $urandom_range(7, 0);
    cmd_data  = $urandom_range(15, 0);
    cmd_len   = $urandom_range(255, 0);
  endtask

  task automatic wait_done(output int cycles, output bit got);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (done) got = 1'b1;
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    rst_n      = 1'b0;
    preset_en  = 1'b1;
    preset_val = 4'h3;
    @(posedge clk); #1;
    preset_en = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (j !== 4'h0 || k !== 4'h0) begin n_fail++; $display("FAIL reset_jk j=%h k=%h want 0/0", j, k); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", cmd_ready); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags busy=%b done=%b err=%b want 000", busy, done, err); end
    n_checks++; if (result !== 4'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", cmd_ready); end
    n_checks++; if (bank !== 4'h3) begin n_fail++; $display("FAIL reset_bank_kept got %h want 3", bank); end
  endtask

  task automatic test_load();
    issue(3'b001, 4'hA, 8'd0, {1'b0, 4'hA});
    n_checks++; if (j !== 4'b1010 || k !== 4'b0101) begin n_fail++; $display("FAIL load_drive j=%b k=%b want 1010/0101", j, k); end
    n_checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL load_busy busy=%b ready=%b want 1/0", busy, cmd_ready); end
    wait_done(cyc, seen);
    n_checks++; if (!seen || cyc != 2) begin n_fail++; $display("FAIL load_latency got %0d (seen %0b) want 2", cyc, seen); end
    exp = exp_q.pop_front();
    n_checks++; if ({err, result} !== exp) begin n_fail++; $display("FAIL load_result got %h want %h", {err, result}, exp); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL load_done_pulse got %b want 0", done); end
  endtask

  task automatic test_toggle_count();
    issue(3'b011, 4'h5, 8'd0, {1'b0, 4'hF});
    n_checks++; if (j !== 4'h5 || k !== 4'h5) begin n_fail++; $display("FAIL toggle_drive j=%h k=%h want 5/5", j, k); end
    wait_done(cyc, seen);
    n_checks++; if (!seen || cyc != 2) begin n_fail++; $display("FAIL toggle_latency got %0d want 2", cyc); end
    exp = exp_q.pop_front();
    n_checks++; if ({err, result} !== exp) begin n_fail++; $display("FAIL toggle_result got %h want %h", {err, result}, exp); end
    issue(3'b100, 4'h0, 8'd3, {1'b0, 4'h2});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (bank !== i[3:0] || done !== 1'b0) begin n_fail++; $display("FAIL count_up_step%0d bank=%h done=%b want %h/0", i, bank, done, i[3:0]); end
    end
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    n_checks++; if (done !== 1'b1 || {err, result} !== exp) begin n_fail++; $display("FAIL count_up_done done=%b got %h want 1/%h", done, {err, result}, exp); end
  endtask

  task automatic test_count_zero_down();
    issue(3'b101, 4'h0, 8'd0, {1'b0, 4'h2});
    n_checks++; if (j !== 4'h0 || k !== 4'h0) begin n_fail++; $display("FAIL len0_jk j=%h k=%h want 0/0", j, k); end
    wait_done(cyc, seen);
    n_checks++; if (!seen || cyc != 1) begin n_fail++; $display("FAIL len0_latency got %0d want 1", cyc); end
    exp = exp_q.pop_front();
    n_checks++; if ({err, result} !== exp) begin n_fail++; $display("FAIL len0_result got %h want %h", {err, result}, exp); end
    issue(3'b101, 4'h0, 8'd3, {1'b0, 4'hF});
    wait_done(cyc, seen);
    n_checks++; if (!seen || cyc != 4) begin n_fail++; $display("FAIL down_latency got %0d want 4", cyc); end
    exp = exp_q.pop_front();
    n_checks++; if ({err, result} !== exp) begin n_fail++; $display("FAIL down_result got %h want %h", {err, result}, exp); end
  endtask

  task automatic test_illegal();
    issue(3'b110, 4'h3, 8'd5, {1'b1, 4'hF});
    n_checks++; if (j !== 4'h0 || k !== 4'h0) begin n_fail++; $display("FAIL illegal_jk j=%h k=%h want 0/0", j, k); end
    wait_done(cyc, seen);
    n_checks++; if (!seen || cyc != 1 || err !== 1'b1) begin n_fail++; $display("FAIL illegal_err cyc=%0d err=%b want 1/1", cyc, err); end
    exp = exp_q.pop_front();
    n_checks++; if ({err, result} !== exp || bank !== 4'hF) begin n_fail++; $display("FAIL illegal_result got %h bank=%h want %h/f", {err, result}, bank, exp); end
    @(posedge clk); #1;
    n_checks++; if (err !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse err=%b done=%b want 0/0", err, done); end
  endtask

  task automatic test_back_to_back();
    issue(3'b100, 4'h0, 8'd2, {1'b0, 4'h1});
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_data  = 4'h6;
    cmd_len   = 8'd0;
    exp_q.push_back({1'b0, 4'h6});
    wait_done(cyc, seen);
    n_checks++; if (!seen || cyc != 3) begin n_fail++; $display("FAIL b2b_count_latency got %0d want 3", cyc); end
    exp = exp_q.pop_front();
    n_checks++; if ({err, result} !== exp) begin n_fail++; $display("FAIL b2b_count_result got %h want %h", {err, result}, exp); end
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done ready=%b busy=%b want 1/0", cmd_ready, busy); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b1 || j !== 4'b0110 || k !== 4'b1001) begin n_fail++; $display("FAIL b2b_load_accept busy=%b j=%b k=%b want 1/0110/1001", busy, j, k); end
    cmd_valid = 1'b0;
    cmd_op    = 3'b010;
    cmd_data  = 4'h9;
    wait_done(cyc, seen);
    n_checks++; if (!seen || cyc != 2) begin n_fail++; $display("FAIL b2b_load_latency got %0d want 2", cyc); end
    exp = exp_q.pop_front();
    n_checks++; if ({err, result} !== exp) begin n_fail++; $display("FAIL b2b_load_result got %h want %h", {err, result}, exp); end
  endtask

  task automatic test_reset_mid();
    issue(3'b010, 4'h0, 8'd0, {1'b0, 4'h0});
    wait_done(cyc, seen);
    exp = exp_q.pop_front();
    n_checks++; if (!seen || {err, result} !== exp) begin n_fail++; $display("FAIL clear_result got %h want %h", {err, result}, exp); end
    issue(3'b100, 4'h0, 8'd10, {1'b0, 4'h0});
    void'(exp_q.pop_back());
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (bank !== i[3:0]) begin n_fail++; $display("FAIL abort_step%0d bank=%h want %h", i, bank, i[3:0]); end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bank !== 4'h4 || j !== 4'h0 || k !== 4'h0) begin n_fail++; $display("FAIL abort_edge bank=%h j=%h k=%h want 4/0/0", bank, j, k); end
    n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_flags done=%b ready=%b busy=%b want 0/0/0", done, cmd_ready, busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || bank !== 4'h4) begin n_fail++; $display("FAIL abort_release ready=%b done=%b bank=%h want 1/0/4", cmd_ready, done, bank); end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cmd_valid  = 1'b0;
    cmd_op     = 3'b000;
    cmd_data   = '0;
    cmd_len    = '0;
    preset_en  = 1'b0;
    preset_val = '0;
    rst_n      = 1'b0;
    #1;
    test_reset();
    test_load();
    test_toggle_count();
    test_count_zero_down();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL queue_drained got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
